// File: rtl/mem_wb_byte_bridge.sv
// mem_wb_byte_bridge
//   Wishbone classic slave that splits each 32-bit access into byte-wide
//   accesses to a 16 KB byte memory with a one-cycle registered read port.
//   Lanes are big-endian: lane k uses wb_sel_i[3-k] and data byte
//   [31-8k:24-8k] and is placed at mem_adr = {wb_adr_i[13:2], k}.
//
// Parameters
//   BASE_ADR   base of the 16 KB window (bits [31:14] significant)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i   Wishbone cycle / strobe / write
//   wb_adr_i, wb_sel_i, wb_dat_i  byte address, lane selects, write data
//   wb_dat_o, wb_ack_o, wb_err_o  read data, acknowledge, error
//   mem_adr, mem_dat_o, mem_dat_i byte-memory address, write data, read data
//   mem_we, mem_en                byte-memory write enable, enable
//
// Build option
//   MEM_WB_BRIDGE_RANGE_CHECK_EN  when defined, requests outside the BASE_ADR
//                                 window end with a one-cycle wb_err_o and no
//                                 memory access; otherwise addresses alias on
//                                 wb_adr_i[13:0] and wb_err_o is tied low.

module mem_wb_byte_bridge #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [13:0] mem_adr,
    output logic [7:0]  mem_dat_o,
    input  logic [7:0]  mem_dat_i,
    output logic        mem_we,
    output logic        mem_en
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        DONE
    } state_t;

    state_t      state, state_d;
    logic [11:0] adr_q;
    logic        we_q;
    logic [31:0] dat_q;
    logic [3:0]  rem_q;        // lanes still to issue, bit k = lane k
    logic [3:0]  rem_next;
    logic [1:0]  lane;
    logic        cap_pending;  // a read lane was issued last cycle
    logic [1:0]  cap_lane;
    logic        req;
    logic        range_err;
    logic        err_q;
    logic        unused_bits;

    assign req = wb_cyc_i & wb_stb_i;

    // Address bits outside the byte-window index are deliberately ignored.
    assign unused_bits = ^{wb_adr_i[31:14], wb_adr_i[1:0], BASE_ADR};

`ifdef MEM_WB_BRIDGE_RANGE_CHECK_EN
    assign range_err = (wb_adr_i[31:14] != BASE_ADR[31:14]);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req) begin
            err_q <= range_err;
        end
    end
`else
    assign range_err = 1'b0;
    assign err_q     = 1'b0;
`endif

    // Lowest pending lane is issued first (ascending k).
    always_comb begin
        lane = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (rem_q[3 - i]) begin
                lane = 2'(3 - i);
            end
        end
        rem_next = rem_q & ~(4'b0001 << lane);
    end

    always_comb begin
        state_d   = state;
        wb_ack_o  = 1'b0;
        wb_err_o  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_dat_o = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (range_err || wb_sel_i == 4'b0000) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Issue is gated by wb_cyc_i so an abandoned cycle
                // touches no further lanes.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    mem_en  = 1'b1;
                    mem_we  = we_q;
                    mem_adr = {adr_q, lane};
                    if (we_q) begin
                        case (lane)
                            2'd0:    mem_dat_o = dat_q[31:24];
                            2'd1:    mem_dat_o = dat_q[23:16];
                            2'd2:    mem_dat_o = dat_q[15:8];
                            default: mem_dat_o = dat_q[7:0];
                        endcase
                    end
                    if (rem_next == 4'b0000) begin
                        state_d = we_q ? DONE : CAPT;
                    end
                end
            end
            CAPT: begin
                state_d = wb_cyc_i ? DONE : IDLE;
            end
            DONE: begin
                wb_ack_o = ~err_q;
                wb_err_o = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            dat_q       <= '0;
            rem_q       <= '0;
            cap_pending <= 1'b0;
            cap_lane    <= '0;
            wb_dat_o    <= '0;
        end else begin
            state       <= state_d;
            cap_pending <= mem_en & ~mem_we;
            cap_lane    <= lane;

            // Memory data lags its issue by one cycle; ~cap_lane == 3-k.
            if (cap_pending) begin
                wb_dat_o[{~cap_lane, 3'b000} +: 8] <= mem_dat_i;
            end

            if (state == IDLE && req) begin
                adr_q <= wb_adr_i[13:2];
                we_q  <= wb_we_i;
                dat_q <= wb_dat_i;
                rem_q <= {wb_sel_i[0], wb_sel_i[1], wb_sel_i[2], wb_sel_i[3]};
                if (!wb_we_i) begin
                    wb_dat_o <= '0;
                end
            end else if (mem_en) begin
                rem_q <= rem_next;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_byte_bridge.sv
// Testbench for mem_wb_byte_bridge: byte memory model with a registered
// read port, a shadow byte array for expected contents, and a scoreboard
// of expected transaction results checked when the bridge acknowledges.

module tb_mem_wb_byte_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o;
    logic [13:0] mem_adr;
    logic [7:0]  mem_dat_o, mem_dat_i;
    logic        mem_we, mem_en;

    always #5 clk = ~clk;

    mem_wb_byte_bridge #(.BASE_ADR(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .mem_adr   (mem_adr),
        .mem_dat_o (mem_dat_o),
        .mem_dat_i (mem_dat_i),
        .mem_we    (mem_we),
        .mem_en    (mem_en)
    );

    logic [7:0] mem    [16384];
    logic [7:0] shadow [16384];
    logic [7:0] rd_q;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_adr] <= mem_dat_o;
            else        rd_q <= mem[mem_adr];
        end
    end
    assign mem_dat_i = rd_q;

    typedef struct {
        int          lat;
        int          n;
        logic        we;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input logic [13:0] a);
        check($sformatf("mem[%h]", a), {24'h0, mem[a]}, {24'h0, shadow[a]});
    endtask

    // Caller is at a negedge with the bridge idle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
        exp_t e;
        exp_t got;
        int   k;
        int   en_cnt;
        bit   done;
        logic [13:0] a;
        e.we  = we;
        e.dat = '0;
        e.n   = 0;
`ifdef MEM_WB_BRIDGE_RANGE_CHECK_EN
        e.err = (adr[31:14] != 18'h0);
`else
        e.err = 1'b0;
`endif
        if (!e.err) begin
            for (int j = 0; j < 4; j++) begin
                if (sel[3 - j]) begin
                    a = {adr[13:2], 2'(j)};
                    e.n++;
                    if (we) shadow[a] = dat[31 - 8*j -: 8];
                    else    e.dat[31 - 8*j -: 8] = shadow[a];
                end
            end
        end
        if (e.err || e.n == 0) e.lat = 1;
        else                   e.lat = we ? e.n + 1 : e.n + 2;
        sb.push_back(e);

        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        k = 0; en_cnt = 0; done = 0;
        while (!done && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (mem_en) en_cnt++;
            if (wb_ack_o || wb_err_o) done = 1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        got = sb.pop_front();
        check("latency", k, got.lat);
        check("ack", {31'h0, wb_ack_o}, {31'h0, ~got.err});
        check("err", {31'h0, wb_err_o}, {31'h0, got.err});
        check("mem_en_count", en_cnt, got.n);
        if (!got.we && !got.err) check("rdata", wb_dat_o, got.dat);
        @(posedge clk); @(negedge clk);
        check("ack_single", {31'h0, wb_ack_o | wb_err_o}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
        repeat (2) @(negedge clk);
        check("rst_state", {wb_dat_o[23:0], wb_ack_o, wb_err_o, mem_en, mem_we, 4'h0},
              32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_mem", {10'h0, mem_adr, mem_dat_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Full word write then read.
        xfer(1'b1, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) check_mem(14'h2000 + 14'(i));
        check("mem_2000_DE", {24'h0, mem[14'h2000]}, 32'hDE);
        xfer(1'b0, 32'h0000_2000, 4'hF, 32'h0);

        // Byte write into a word, then half read.
        xfer(1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344);
        xfer(1'b1, 32'h0000_0010, 4'b0010, 32'h0000_5A00);
        check("mem_12", {24'h0, mem[14'h0012]}, 32'h5A);
        check_mem(14'h0013);
        xfer(1'b0, 32'h0000_0013, 4'b1100, 32'h0);
        check("rdata_half", wb_dat_o, 32'h1122_0000);

        // Write leaves read data intact; skipped lanes.
        xfer(1'b1, 32'h0000_0300, 4'hF, 32'h0);
        xfer(1'b1, 32'h0000_0300, 4'b1010, 32'h1122_3344);
        check("dat_hold", wb_dat_o, 32'h1122_0000);
        xfer(1'b0, 32'h0000_0300, 4'hF, 32'h0);
        xfer(1'b0, 32'h0000_0300, 4'b0001, 32'h0);

        // No lanes selected.
        xfer(1'b0, 32'h0000_0300, 4'b0000, 32'h0);
        xfer(1'b1, 32'h0000_0300, 4'b0000, 32'hFFFF_FFFF);

        // Abandon a write after two lanes.
        xfer(1'b1, 32'h0000_0100, 4'hF, 32'h5555_5555);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
        wb_adr_i = 32'h100; wb_sel_i = 4'hF; wb_dat_i = 32'hA1B2_C3D4;
        @(posedge clk); @(negedge clk);
        check("abort_l0", {17'h0, mem_en, mem_adr}, {17'h0, 1'b1, 14'h100});
        @(posedge clk); @(negedge clk);
        check("abort_l1", {17'h0, mem_en, mem_adr}, {17'h0, 1'b1, 14'h101});
        @(posedge clk); @(negedge clk);
        wb_cyc_i = 0; wb_stb_i = 0;
        #1;
        check("abort_gate", {31'h0, mem_en}, 32'h0);
        @(posedge clk); @(negedge clk);
        check("abort_idle", {29'h0, wb_ack_o, wb_err_o, mem_en}, 32'h0);
        shadow[14'h100] = 8'hA1;
        shadow[14'h101] = 8'hB2;
        for (int i = 0; i < 4; i++) check_mem(14'h100 + 14'(i));
        xfer(1'b0, 32'h0000_0100, 4'hF, 32'h0);

        // Reset in the middle of a read.
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0;
        wb_adr_i = 32'h2000; wb_sel_i = 4'hF;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("rst_mid_l1", {18'h0, mem_adr}, 32'h2001);
        rst = 1; wb_cyc_i = 0; wb_stb_i = 0;
        @(posedge clk); @(negedge clk);
        check("rst_mid_ctl", {27'h0, wb_ack_o, wb_err_o, mem_en, mem_we, 1'b0}, 32'h0);
        check("rst_mid_dat", wb_dat_o, 32'h0);
        check("rst_mid_mem", {10'h0, mem_adr, mem_dat_o}, 32'h0);
        rst = 0;
        @(negedge clk);
        xfer(1'b0, 32'h0000_2000, 4'hF, 32'h0);

        // Out-of-window address: aliases, or errors with range checking.
        xfer(1'b1, 32'h0000_4000, 4'hF, 32'hCAFE_F00D);
        xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_wb_byte_bridge.md
MEM_WB_BYTE_BRIDGE -- requirements
Module: mem_wb_byte_bridge

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_0000; base of the 16 KB window; only bits [31:14] are significant.
REQ-002 SHALL have port clk, input, 1 bit; sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset, synchronous, active-high.
REQ-004 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, each input, 1 bit; Wishbone classic cycle, strobe and write.
REQ-005 SHALL have ports wb_adr_i (input, 32 bits), wb_sel_i (input, 4 bits) and wb_dat_i (input, 32 bits); byte address, lane selects and write data.
REQ-006 SHALL have ports wb_dat_o (output, 32 bits), wb_ack_o (output, 1 bit) and wb_err_o (output, 1 bit); read data, acknowledge and error.
REQ-007 SHALL have ports mem_adr (output, 14 bits), mem_dat_o (output, 8 bits) and mem_dat_i (input, 8 bits); byte-memory address, write data and read data. mem_dat_i is registered inside the memory and valid the cycle after mem_en.
REQ-008 SHALL have ports mem_we and mem_en, each output, 1 bit; byte-memory write enable and enable.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, CAPT and DONE.
REQ-010 In IDLE with wb_cyc_i&wb_stb_i=1 (cycle T), SHALL latch adr, we, sel and dat, then go to ISSUE; sel=0 SHALL go directly to DONE.
REQ-011 Lane mapping is big-endian: lane k (k=0..3) uses sel[3-k] and data bits [31-8k:24-8k], at mem_adr={adr[13:2],k[1:0]}; wb_adr_i[1:0] SHALL be ignored.
REQ-012 ISSUE SHALL present one selected lane per cycle in ascending k, skipping unselected lanes, with mem_en=1 and mem_we=latched we; mem_dat_o SHALL be the lane byte on writes and 0 on reads.
REQ-013 Reads SHALL capture mem_dat_i into the matching wb_dat_o lane one cycle after issue, pipelined with the next issue; unselected lanes SHALL read 0.
REQ-014 After the last lane issues, a write SHALL go to DONE and a read SHALL go to CAPT (one final capture), then to DONE.
REQ-015 DONE SHALL assert wb_ack_o for exactly one cycle and return to IDLE. For N selected lanes, the ack cycle SHALL be T+N+1 for writes, T+N+2 for reads, and T+1 for sel=0.
REQ-016 Requests SHALL NOT be accepted in the DONE cycle.
REQ-017 wb_dat_o SHALL hold until the next read is accepted; it is not cleared by writes.
REQ-018 mem_en, mem_we and mem_dat_o SHALL be 0 outside ISSUE.
REQ-019 If wb_cyc_i falls in ISSUE or CAPT, SHALL return to IDLE next cycle, issue no further lanes and give no ack; bytes already written SHALL remain written.
REQ-020 Lane count SHALL be a 2-bit index; no wrap past lane 3.

Reset
REQ-021 rst=1 SHALL force IDLE from any state, including mid-transaction.
REQ-022 rst=1 SHALL drive wb_ack_o=0, wb_err_o=0, wb_dat_o=0, mem_en=0, mem_we=0, mem_adr=0 and mem_dat_o=0 in the following cycle.

Configuration
REQ-023 Macro MEM_WB_BRIDGE_RANGE_CHECK_EN: when defined, a request with wb_adr_i[31:14]!=BASE_ADR[31:14] SHALL go directly to DONE without memory access, and SHALL assert wb_err_o (not wb_ack_o) for one cycle at T+1.
REQ-024 When MEM_WB_BRIDGE_RANGE_CHECK_EN is undefined, wb_err_o SHALL be tied 0 and addresses SHALL alias on wb_adr_i[13:0].

Verification
REQ-025 Full-word write then read: write 0x0000_2000, sel=F, data 0xDEADBEEF -> mem bytes DE,AD,BE,EF at 0x2000..0x2003 and ack at T+5; read -> wb_dat_o=0xDEADBEEF with ack at T+6.
REQ-026 Byte and half access: write sel=4'b0010 data 0x0000_5A00 to 0x10 -> single mem write, 0x5A at 0x12, ack at T+2; read sel=4'b1100 -> 2 issues, unselected lanes 0.
REQ-027 sel=0 request -> no mem_en, ack at T+1.
REQ-028 Drop wb_cyc_i after 2 of 4 write lanes -> only lanes 0 and 1 written, no ack, IDLE next cycle.
REQ-029 rst asserted during a read at ISSUE lane 1 -> all outputs 0 next cycle, FSM IDLE; a fresh read afterwards completes normally.
REQ-030 With MEM_WB_BRIDGE_RANGE_CHECK_EN and BASE_ADR=0, access to 0x0000_4000 -> wb_err_o at T+1, no mem_en; without the macro, the same access aliases to 0x0000 and acks normally.
